clk_freq_meter: RTL and testbench

Frequency-measurement block that counts rising edges of an external, asynchronous clock-like input over a programmable gate window of system-clock cycles. It is the receive-side counterpart of the divided-clock outputs from the clock generator: it samples a divided clock brought back in on a pin and reports its edge count per window. The result is used for on-silicon checking of divider ratios. Single clock domain; the measured input is synchronised internally.

---
 rtl/clk_freq_meter_if.sv | 29 ++
 rtl/clk_freq_meter.sv | 153 +++++++++++++++
 tb/tb_clk_freq_meter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_freq_meter_if
// Description : Control/result bundle of the clock frequency meter.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_freq_meter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              valid;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    modport master (
        output start, abort, gate_len,
        input  busy, valid, count, ovf
    );

    modport slave (
        input  start, abort, gate_len,
        output busy, valid, count, ovf
    );
endinterface
`default_nettype wire

// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_freq_meter
// Description : Counts rising edges of an asynchronous input over a gate
//               window of clk cycles. Define CLK_METER_CONT_EN for
//               back-to-back continuous windows.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_freq_meter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          meas_in,
    clk_freq_meter_if.slave    bus
);

    typedef logic [1:0] state_t;
    localparam state_t            c_IDLE     = 2'd0;
    localparam state_t            c_MEASURE  = 2'd1;
    localparam state_t            c_DONE     = 2'd2;
    localparam logic [GATE_W-1:0] c_GATE_ONE = GATE_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_step;
    logic              w_latch;
    logic              w_zero;

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              w_edge;

    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic [CNT_W-1:0]  w_edge_cnt_nxt;
    logic              r_acc;
    logic              w_acc_nxt;
    logic              w_sat;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    assign w_edge = r_s2 & ~r_s3;

    // Saturate instead of wrapping; a blocked increment marks the window overflowed.
    always_comb begin
        w_sat          = &r_edge_cnt;
        w_edge_cnt_nxt = (w_edge && !w_sat) ? r_edge_cnt + 1'b1 : r_edge_cnt;
        w_acc_nxt      = r_acc | (w_edge & w_sat);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_latch     = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_load = 1'b1;
                    if (bus.gate_len == '0) begin
                        w_zero      = 1'b1;
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_MEASURE;
                    end
                end
            end
            c_MEASURE: begin
                // Abort beats gate expiry: the window is dropped without a result.
                if (bus.abort) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_gate_cnt == c_GATE_ONE) begin
                        w_latch     = 1'b1;
                        w_state_nxt = c_DONE;
                    end
                end
            end
            c_DONE: begin
`ifdef CLK_METER_CONT_EN
                if (bus.abort || bus.gate_len == '0) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = c_MEASURE;
                end
`else
                w_state_nxt = c_IDLE;
`endif
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_acc      <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1 <= meas_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (w_load) begin
                r_gate_cnt <= bus.gate_len;
                r_edge_cnt <= '0;
                r_acc      <= 1'b0;
            end else if (w_step) begin
                r_gate_cnt <= r_gate_cnt - 1'b1;
                r_edge_cnt <= w_edge_cnt_nxt;
                r_acc      <= w_acc_nxt;
            end

            // Result is captured on entry to DONE so it is fresh while valid is high.
            if (w_latch) begin
                r_count <= w_edge_cnt_nxt;
                r_ovf   <= w_acc_nxt;
            end else if (w_zero) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign bus.busy  = (r_state == c_MEASURE);
    assign bus.valid = (r_state == c_DONE);
    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_freq_meter
// Description : Directed vector bench for clk_freq_meter (16-bit and 4-bit
//               counter instances sharing one measured input).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        meas_in;
    logic        start;
    logic        abort;
    logic        sel;
    logic [15:0] gate_len;
    int          period = 0;
    int          ph = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    clk_freq_meter_if #(.CNT_W(16), .GATE_W(16)) if_a ();
    clk_freq_meter_if #(.CNT_W(4),  .GATE_W(16)) if_b ();

    assign if_a.start    = start & ~sel;
    assign if_a.abort    = abort & ~sel;
    assign if_a.gate_len = gate_len;
    assign if_b.start    = start & sel;
    assign if_b.abort    = abort & sel;
    assign if_b.gate_len = gate_len;

    clk_freq_meter #(.CNT_W(16), .GATE_W(16)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .meas_in (meas_in),
        .bus     (if_a)
    );

    clk_freq_meter #(.CNT_W(4), .GATE_W(16)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .meas_in (meas_in),
        .bus     (if_b)
    );

    logic        busy_m;
    logic        valid_m;
    logic        ovf_m;
    logic [15:0] count_m;
    assign busy_m  = sel ? if_b.busy  : if_a.busy;
    assign valid_m = sel ? if_b.valid : if_a.valid;
    assign ovf_m   = sel ? if_b.ovf   : if_a.ovf;
    assign count_m = sel ? {12'd0, if_b.count} : if_a.count;

    // Strictly periodic measured signal, high for period/2 cycles.
    always @(negedge clk) begin
        if (period == 0) begin
            meas_in = 1'b0;
            ph      = 0;
        end else begin
            meas_in = (ph < period / 2);
            ph      = (ph + 1 >= period) ? 0 : ph + 1;
        end
    end

    typedef struct {
        bit sel;
        int gate;
        int period;
        int exp_count;
        int exp_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic settle(input int p);
        period = p;
        repeat (3 * p + 12) @(negedge clk);
    endtask

    // Start a window in cycle T and observe T+1 .. T+gate+2.
    task automatic run(input bit s, input int gate, input int abort_at,
                       input int restart_at, input int rst_at, input int snap_at,
                       output int nbusy, output int nvalid, output int vpos,
                       output int vcnt, output int vovf, output int snap);
        sel      = s;
        @(negedge clk);
        start    = 1'b1;
        gate_len = gate[15:0];
        nbusy = 0; nvalid = 0; vpos = -1; vcnt = -1; vovf = -1; snap = -1;
        for (int i = 1; i <= gate + 2; i++) begin
            @(negedge clk);
            if (busy_m) nbusy++;
            if (valid_m) begin
                nvalid++;
                if (vpos < 0) begin
                    vpos = i;
                    vcnt = int'(count_m);
                    vovf = int'(ovf_m);
                end
            end
            if (i == snap_at)
                snap = int'({13'd0, busy_m, valid_m, ovf_m, count_m});
            start = (i == restart_at);
            if (i == restart_at) gate_len = 16'd5;
            abort = (i == abort_at);
`ifdef CLK_METER_CONT_EN
            if (i == gate + 1 && abort_at < 0) abort = 1'b1;
`endif
            rst_n = (i != rst_at);
        end
        abort = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    int nb, nv, vp, vc, vo, sn, bad, vseen;

    initial begin
        vecs[0]  = '{1'b0, 100, 10, 10, 0};
        vecs[1]  = '{1'b0,  50,  0,  0, 0};
        vecs[2]  = '{1'b0,   0,  0,  0, 0};
        vecs[3]  = '{1'b0,   1,  0,  0, 0};
        vecs[4]  = '{1'b0, 100,  5, 20, 0};
        vecs[5]  = '{1'b0,  70,  7, 10, 0};
        vecs[6]  = '{1'b0, 100, 20,  5, 0};
        vecs[7]  = '{1'b1, 100,  4, 15, 1};
        vecs[8]  = '{1'b1, 100, 20,  5, 0};
        vecs[9]  = '{1'b1,  90,  6, 15, 0};
        vecs[10] = '{1'b1,  96,  6, 15, 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; gate_len = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_a", int'({if_a.busy, if_a.valid, if_a.ovf, if_a.count}), 0);
        check("reset_b", int'({if_b.busy, if_b.valid, if_b.ovf, if_b.count}), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            settle(vecs[k].period);
            run(vecs[k].sel, vecs[k].gate, -1, -1, -1, -1, nb, nv, vp, vc, vo, sn);
            check($sformatf("vec%0d_busy_cycles", k), nb, vecs[k].gate);
            check($sformatf("vec%0d_valid_pulses", k), nv, 1);
            check($sformatf("vec%0d_valid_pos", k), vp, vecs[k].gate + 1);
            check($sformatf("vec%0d_count", k), vc, vecs[k].exp_count);
            check($sformatf("vec%0d_ovf", k), vo, vecs[k].exp_ovf);
        end

        // Start pulse during MEASURE must not disturb the window.
        settle(10);
        run(1'b0, 100, -1, 10, -1, -1, nb, nv, vp, vc, vo, sn);
        check("restart_ignored_pos", vp, 101);
        check("restart_ignored_busy", nb, 100);
        check("restart_ignored_count", vc, 10);

        // Abort mid-window: no result, previous count kept.
        run(1'b0, 100, 40, -1, -1, 41, nb, nv, vp, vc, vo, sn);
        check("abort_no_valid", nv, 0);
        check("abort_busy_cycles", nb, 40);
        check("abort_snapshot", sn, 10);

        // Abort in the final counted cycle wins over gate expiry.
        run(1'b0, 20, 20, -1, -1, 21, nb, nv, vp, vc, vo, sn);
        check("abort_expiry_no_valid", nv, 0);
        check("abort_expiry_snapshot", sn, 10);

        // Reset mid-window clears everything.
        run(1'b0, 100, -1, -1, 30, 31, nb, nv, vp, vc, vo, sn);
        check("reset_mid_snapshot", sn, 0);
        check("reset_mid_no_valid", nv, 0);
        run(1'b0, 100, -1, -1, -1, -1, nb, nv, vp, vc, vo, sn);
        check("after_reset_pos", vp, 101);
        check("after_reset_count", vc, 10);

`ifdef CLK_METER_CONT_EN
        settle(8);
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; gate_len = 16'd64;
        bad = 0; vseen = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (valid_m) begin
                vseen++;
                if (i % 65 != 0) bad++;
                check($sformatf("cont_count_w%0d", vseen), int'(count_m >= 16'd7 && count_m <= 16'd9), 1);
            end
            start = 1'b0;
            abort = (i == 280);
        end
        abort = 1'b0;
        check("cont_valid_misplaced", bad, 0);
        check("cont_valid_pulses", vseen, 4);
        check("cont_busy_after_abort", int'(busy_m), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
